// File: rtl/pdm_sine_decoder.sv
// Receive-side decoder for the pure sine generator's PDM stream: boxcar decimation,
// min/max tracking and period measurement from hysteretic rising mid-scale crossings.
module pdm_sine_decoder #(
    parameter int WIN_LOG2 = 8,
    parameter int HYST     = 8,
    parameter int PER_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                pdm_in,
    input  logic                clear_stats,
    output logic [WIN_LOG2:0]   sample,
    output logic                sample_valid,
    output logic [WIN_LOG2:0]   sample_max,
    output logic [WIN_LOG2:0]   sample_min,
    output logic [PER_W-1:0]    period,
    output logic                period_valid,
    output logic                stale
);

    localparam logic [1:0] ST_UNKNOWN = 2'd0;
    localparam logic [1:0] ST_BELOW   = 2'd1;
    localparam logic [1:0] ST_ABOVE   = 2'd2;

    localparam int MID = 2 ** (WIN_LOG2 - 1);
    localparam logic [WIN_LOG2:0] FULL_V = (WIN_LOG2 + 1)'(2 ** WIN_LOG2);
    localparam logic [WIN_LOG2:0] HI_TH  = (WIN_LOG2 + 1)'(MID + HYST);
    localparam logic [WIN_LOG2:0] LO_TH  = (WIN_LOG2 + 1)'(MID - HYST);
    localparam logic [PER_W-1:0]  PC_MAX  = '1;
    localparam logic [PER_W-1:0]  PC_LAST = {{(PER_W - 1){1'b1}}, 1'b0};

    logic                  sync1;
    logic                  b;
    logic [WIN_LOG2-1:0]   wc;
    logic [WIN_LOG2:0]     acc;
    logic [1:0]            state;
    logic [1:0]            state_nx;
    logic                  armed;
    logic                  armed_nx;
    logic                  rise;
    logic [PER_W-1:0]      pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            b     <= 1'b0;
        end else begin
            sync1 <= pdm_in;
            b     <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wc           <= '0;
            acc          <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (en) begin
                wc <= wc + 1'b1;
                if (wc == '1) begin
                    sample       <= acc + (WIN_LOG2 + 1)'(b);
                    sample_valid <= 1'b1;
                    acc          <= '0;
                end else begin
                    acc <= acc + (WIN_LOG2 + 1)'(b);
                end
            end
        end
    end

    // Clear has priority so the sample arriving with it is not folded into the new stats.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_max <= '0;
            sample_min <= FULL_V;
        end else if (clear_stats) begin
            sample_max <= '0;
            sample_min <= FULL_V;
        end else if (sample_valid) begin
            if (sample > sample_max) sample_max <= sample;
            if (sample < sample_min) sample_min <= sample;
        end
    end

    always_comb begin
        state_nx = state;
        armed_nx = armed;
        rise     = 1'b0;
        case (state)
            ST_UNKNOWN: begin
                if (sample >= HI_TH)      state_nx = ST_ABOVE;
                else if (sample <= LO_TH) state_nx = ST_BELOW;
            end
            ST_BELOW: begin
                if (sample >= HI_TH) begin
                    state_nx = ST_ABOVE;
                    rise     = 1'b1;
                end
            end
            ST_ABOVE: begin
                if (sample <= LO_TH) begin
                    state_nx = ST_BELOW;
                    armed_nx = 1'b1;
                end
            end
            default: begin
                state_nx = ST_UNKNOWN;
                armed_nx = 1'b0;
            end
        endcase
    end

    // Saturation is acted on only on the step into PC_MAX, otherwise UNKNOWN would be
    // re-forced every sample and the machine could never reach a crossing again.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_UNKNOWN;
            armed        <= 1'b0;
            pc           <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            stale        <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (sample_valid) begin
                if (rise) begin
                    state <= state_nx;
                    armed <= armed_nx;
                    pc    <= '0;
                    stale <= 1'b0;
                    if (armed && !stale) begin
                        period       <= pc + 1'b1;
                        period_valid <= 1'b1;
                    end
                end else if (pc != PC_MAX) begin
                    pc <= pc + 1'b1;
                    if (pc == PC_LAST) begin
                        stale <= 1'b1;
                        state <= ST_UNKNOWN;
                        armed <= 1'b0;
                    end else begin
                        state <= state_nx;
                        armed <= armed_nx;
                    end
                end else begin
                    state <= state_nx;
                    armed <= armed_nx;
                end
            end
        end
    end

endmodule

// File: doc/pdm_sine_decoder.md
# pdm_sine_decoder

- Receive-side companion to the pure sine generator.
- Takes the generator's 1-bit pulse-density output, recovers amplitude samples with a boxcar decimator and tracks signal minimum and maximum.
- Measures sine period, in samples, from hysteretic rising mid-scale crossings.
- Used in silicon loopback and bench self-check of the generator.

## Interface
Parameters:
- WIN_LOG2, 8: decimation window is 2^WIN_LOG2 clocks.
- HYST, 8: crossing hysteresis, in sample LSBs.
- PER_W, 16: width of the period counter and output.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  when low, the window counter and accumulator hold.
- pdm_in  in  1  asynchronous bitstream from the generator.
- clear_stats  in  1  one-cycle request to re-initialise min/max.
- sample  out  WIN_LOG2+1  count of ones in the last window (0..2^WIN_LOG2).
- sample_valid  out  1  one-cycle strobe for a new `sample`.
- sample_max  out  WIN_LOG2+1  largest sample since reset or clear.
- sample_min  out  WIN_LOG2+1  smallest sample since reset or clear.
- period  out  PER_W  samples between the last two rising crossings.
- period_valid  out  1  one-cycle strobe for a new `period`.
- stale  out  1  period counter has saturated without a crossing.

## Operation
- **Input synchroniser:** `pdm_in` passes through 2 flops. Only the synchronised bit `b` is used.
- **Window counting:** while `en`=1, window counter `wc` (WIN_LOG2 bits) increments every clock and accumulator `acc` adds `b`.
- **End of window:** when `wc`=2^WIN_LOG2-1:
  - `sample` <= `acc`+`b`.
  - `sample_valid` pulses.
  - `acc` <= 0 and `wc` wraps to 0.
- **en low:** `wc`, `acc` and `b` sampling pause; the partial window resumes when `en` returns high. Outputs hold.
- **Min/max update:** on each `sample_valid`, `sample_max` <= max(`sample_max`, `sample`) and `sample_min` <= min(`sample_min`, `sample`). Both update in the cycle after the strobe.
- **clear_stats:** sets `sample_max`=0 and `sample_min`=2^WIN_LOG2.
  - If `clear_stats` coincides with a min/max update, the clear wins and that sample is not folded in.
- **Crossing state machine:** states UNKNOWN, BELOW, ABOVE. MID = 2^(WIN_LOG2-1). It is evaluated on each new sample.
  - UNKNOWN -> ABOVE if sample >= MID+HYST; UNKNOWN -> BELOW if sample <= MID-HYST. Neither transition arms the period measurement.
  - ABOVE -> BELOW if sample <= MID-HYST. This also arms the period measurement.
  - BELOW -> ABOVE if sample >= MID+HYST. This is a rising crossing.
  - Samples inside the band leave the state unchanged.
- **Period counter:** `pc` (PER_W bits) increments on every new sample and saturates at 2^PER_W-1. Saturation sets `stale`=1 and forces the state machine to UNKNOWN, disarmed.
- **Rising crossing:**
  - If armed and not stale: `period` <= `pc`+1 and `period_valid` pulses.
  - In all cases: `pc` <= 0, `stale` <= 0.
  - The first rising crossing after reset, UNKNOWN or saturation produces no `period_valid`.

## Timing
- **Reset values:** `sample`=0, `sample_valid`=0, `sample_max`=0, `sample_min`=2^WIN_LOG2, `period`=0, `period_valid`=0, `stale`=0. Internally: state=UNKNOWN, disarmed, `wc`=`acc`=`pc`=0, synchroniser flops=0.
- **Reset mid-window:** the partial window is discarded. The next full window starts on the first clock after `rst` falls.
- **Input latency:** `pdm_in` reaches `b` after 2 clocks. The first post-reset `sample_valid` occurs 2^WIN_LOG2 clocks after reset release, with `en` held high; the first 2 bits counted are the reset-value 0s.
- **Strobe spacing:** `sample_valid` is high for exactly 1 clock, at least 2^WIN_LOG2 clocks apart.
- **Crossing latency:** `period_valid` asserts 1 clock after the `sample_valid` that caused the crossing. `period` is stable from that cycle until the next `period_valid`.
- **Back-pressure:** none. A downstream block must capture on the strobe.

## Test plan
1. `pdm_in`=0 constant, `en`=1 -> `sample_valid` every 256 clocks with `sample`=0. `sample_min`=0, `sample_max`=0, no `period_valid`.
2. `pdm_in`=1 constant -> `sample`=256 from the second window onward. `sample_max`=256.
3. Alternating 1,0 bitstream -> `sample`=128 every window. State stays UNKNOWN, no `period_valid`.
4. Repeat 4 windows of 25% density (sample 64) then 4 windows of 75% density (sample 192):
   - the first rising crossing gives no strobe;
   - each later crossing gives `period_valid` with `period`=8;
   - `sample_min`=64, `sample_max`=192.
5. Drive ones, assert `en`=0 for 100 clocks mid-window, then release -> that window still reports `sample`=256, delayed by 100 clocks. Separately, pulse `rst` mid-window -> all outputs return to reset values and the next strobe follows 256 clocks later.
6. PER_W=4 with a constant 75% stream -> `stale`=1 after 15 samples and the state goes to UNKNOWN. Restart the scenario 4 pattern -> the first crossing clears `stale` without a strobe, and the next crossing gives `period`=8. Also pulse `clear_stats` on a `sample_valid` cycle -> `sample_max`=0, `sample_min`=256.
